// File: rtl/ifq_pkg.sv
// Shared widths, reset fetch address and the buffered-line record for the fetch queue.
// Latency: none (types and constants only); backpressure: n/a.
package ifq_pkg;

  localparam int INST_W     = 32;
  localparam int LINE_W     = 128;
  localparam int LINE_WORDS = 4;
  localparam int LPC_W      = 28;

  localparam logic [31:0] RESET_PC_DEF = 32'h0;

  // One buffered cache line together with its line-aligned PC (bits [31:4]).
  typedef struct packed {
    logic [LPC_W-1:0]  lpc;
    logic [LINE_W-1:0] line;
  } line_ent_t;

  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:4], 4'b0000};
  endfunction

endpackage

// File: rtl/ifq_line_fifo.sv
// Show-ahead FIFO of cache lines with a synchronous flush; head is valid the cycle after write.
// Writes while full and pops while empty are ignored; flush wins over write and pop.
module ifq_line_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush_i,
  input  logic      wr_vld_i,
  input  line_ent_t wr_dat_i,
  input  logic      pop_i,
  output line_ent_t rd_dat_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  line_ent_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_wr, do_pop;

  assign full_o   = (count_q == FULL_CNT);
  assign empty_o  = (count_q == '0);
  assign do_wr    = wr_vld_i & ~full_o & ~flush_i;
  assign do_pop   = pop_i & ~empty_o & ~flush_i;
  assign rd_dat_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are PTR_W bits wide, so increment wraps modulo DEPTH.
      if (do_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PTR_W{1'b0}}, do_wr} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: fetches 4-word lines, presents one instruction/PC per cycle to dispatch.
// Line return to head valid in 1 cycle; fetch stalls when queue plus in-flight request would overflow.
module ifq
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       icache_pc_in,
  output logic              icache_rd_en,
  input  logic [LINE_W-1:0] icache_dout,
  input  logic              icache_dout_valid,
  output logic [31:0]       pc_out,
  output logic [INST_W-1:0] inst,
  output logic              empty,
  input  logic              rd_en,
  input  logic [31:0]       jump_branch_address,
  input  logic              jump_branch_valid
);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        outst_q, outst_d;
  logic        drop_q, drop_d;
  logic [1:0]  rd_word_q, rd_word_d;
  logic        req_q, req_d;
  logic [31:0] req_pc_q, req_pc_d;

  logic      fifo_full, fifo_empty;
  line_ent_t head, wr_ent;
  logic      issue, line_wr, pop_word, pop_line;
  logic [LINE_WORDS-1:0][INST_W-1:0] head_words;

  // A redirect squashes everything else that happens in the same cycle.
  assign pop_word = rd_en & ~fifo_empty & ~jump_branch_valid;
  assign pop_line = pop_word & (rd_word_q == 2'd3);
  assign line_wr  = icache_dout_valid & ~drop_q & ~jump_branch_valid;
  assign issue    = ~outst_q & ~jump_branch_valid & ~fifo_full;

  assign wr_ent.lpc  = fetch_pc_q[31:4];
  assign wr_ent.line = icache_dout;

  ifq_line_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_line_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (jump_branch_valid),
    .wr_vld_i (line_wr),
    .wr_dat_i (wr_ent),
    .pop_i    (pop_line),
    .rd_dat_o (head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_word_d  = rd_word_q;
    req_d      = issue;
    req_pc_d   = req_pc_q;

    if (issue) begin
      req_pc_d = line_align(fetch_pc_q);
      outst_d  = 1'b1;
    end
    if (icache_dout_valid) begin
      outst_d = 1'b0;
      drop_d  = 1'b0;
    end
    if (line_wr) fetch_pc_d = fetch_pc_q + 32'd16;

    if (jump_branch_valid) begin
      fetch_pc_d = jump_branch_address & ~32'h3;
      rd_word_d  = jump_branch_address[3:2];
      // The in-flight line belongs to the old path; swallow it when it returns.
      if (outst_q && !icache_dout_valid) drop_d = 1'b1;
    end else if (pop_word) begin
      rd_word_d = rd_word_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      rd_word_q  <= 2'd0;
      req_q      <= 1'b0;
      req_pc_q   <= line_align(RESET_PC);
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_word_q  <= rd_word_d;
      req_q      <= req_d;
      req_pc_q   <= req_pc_d;
    end
  end

  assign head_words   = head.line;
  assign icache_rd_en = req_q;
  assign icache_pc_in = req_pc_q;
  assign empty        = fifo_empty;
  assign inst         = fifo_empty ? '0 : head_words[rd_word_q];
  assign pc_out       = fifo_empty ? 32'h0 : {head.lpc, rd_word_q, 2'b00};

endmodule

// File: tb/tb_ifq.sv
// Directed self-checking bench for the instruction fetch queue.
module tb_ifq;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  icache_pc_in;
  logic         icache_rd_en;
  logic [127:0] icache_dout = '0;
  logic         icache_dout_valid = 1'b0;
  logic [31:0]  pc_out;
  logic [31:0]  inst;
  logic         empty;
  logic         rd_en = 1'b0;
  logic [31:0]  jump_branch_address = '0;
  logic         jump_branch_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  ifq #(.DEPTH(4), .PTR_W(2), .RESET_PC(32'h0)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .icache_pc_in        (icache_pc_in),
    .icache_rd_en        (icache_rd_en),
    .icache_dout         (icache_dout),
    .icache_dout_valid   (icache_dout_valid),
    .pc_out              (pc_out),
    .inst                (inst),
    .empty               (empty),
    .rd_en               (rd_en),
    .jump_branch_address (jump_branch_address),
    .jump_branch_valid   (jump_branch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] mkline(input int id);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = 32'hA000_0000 | (id << 8) | w;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; rd_en = 1'b0; jump_branch_valid = 1'b0; icache_dout_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic respond(input logic [127:0] l);
    icache_dout = l;
    icache_dout_valid = 1'b1;
    step();
    icache_dout_valid = 1'b0;
    icache_dout = '0;
  endtask

  task automatic wait_req(output bit found, output logic [31:0] pc);
    found = 1'b0;
    pc = '0;
    for (int i = 0; i < 16; i++) begin
      if (icache_rd_en === 1'b1) begin
        found = 1'b1;
        pc = icache_pc_in;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step(); step();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%h exp=1", empty); end
    checks++; if (icache_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%h exp=0", icache_rd_en); end
    checks++; if (icache_pc_in !== 32'h0) begin errors++; $display("FAIL reset_pc_in got=%h exp=0", icache_pc_in); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got=%h exp=0", pc_out); end
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst got=%h exp=0", inst); end
    rst = 1'b1;
    step();
    checks++; if (icache_rd_en !== 1'b1) begin errors++; $display("FAIL first_req got=%h exp=1", icache_rd_en); end
    checks++; if (icache_pc_in !== 32'h0) begin errors++; $display("FAIL first_req_pc got=%h exp=0", icache_pc_in); end
  endtask

  task automatic test_single_line();
    logic [31:0] exp_inst [4];
    bit seen;
    logic [31:0] seen_pc;
    exp_inst[0] = 32'h11; exp_inst[1] = 32'h22; exp_inst[2] = 32'h33; exp_inst[3] = 32'h44;
    respond({32'h44, 32'h33, 32'h22, 32'h11});
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL line_latency_empty got=%h exp=0", empty); end
    seen = 1'b0; seen_pc = '0;
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (inst !== exp_inst[k]) begin errors++; $display("FAIL single_inst%0d got=%h exp=%h", k, inst, exp_inst[k]); end
      checks++; if (pc_out !== 32'(4*k)) begin errors++; $display("FAIL single_pc%0d got=%h exp=%h", k, pc_out, 32'(4*k)); end
      step();
      if (icache_rd_en === 1'b1 && !seen) begin seen = 1'b1; seen_pc = icache_pc_in; end
    end
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_drained got=%h exp=1", empty); end
    checks++; if (!seen || seen_pc !== 32'h10) begin errors++; $display("FAIL single_next_req got=%h/%h exp=1/00000010", seen, seen_pc); end
  endtask

  task automatic test_fifo_full();
    bit found, seen;
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_req(found, pc);
      checks++; if (!found || pc !== 32'(16*i)) begin errors++; $display("FAIL full_req%0d got=%h/%h exp=1/%h", i, found, pc, 32'(16*i)); end
      respond(mkline(i));
    end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL full_not_empty got=%h exp=0", empty); end
    seen = 1'b0;
    repeat (8) begin
      step();
      if (icache_rd_en === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL full_no_fifth_req got=%h exp=0", seen); end
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (inst !== (32'hA000_0000 | k)) begin errors++; $display("FAIL full_inst%0d got=%h exp=%h", k, inst, 32'hA000_0000 | k); end
      checks++; if (pc_out !== 32'(4*k)) begin errors++; $display("FAIL full_pc%0d got=%h exp=%h", k, pc_out, 32'(4*k)); end
      step();
    end
    rd_en = 1'b0;
    checks++; if (inst !== 32'hA000_0100 || pc_out !== 32'h10) begin errors++; $display("FAIL full_second_head got=%h/%h exp=a0000100/00000010", inst, pc_out); end
    wait_req(found, pc);
    checks++; if (!found || pc !== 32'h40) begin errors++; $display("FAIL full_resume_req got=%h/%h exp=1/00000040", found, pc); end
  endtask

  task automatic test_redirect_drop();
    bit found, seen;
    logic [31:0] pc;
    do_reset();
    wait_req(found, pc);
    respond(mkline(0));
    wait_req(found, pc);
    respond(mkline(1));
    wait_req(found, pc);
    checks++; if (!found || pc !== 32'h20) begin errors++; $display("FAIL drop_req20 got=%h/%h exp=1/00000020", found, pc); end
    jump_branch_address = 32'h0000_010B;
    jump_branch_valid = 1'b1;
    step();
    jump_branch_valid = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drop_flushed got=%h exp=1", empty); end
    seen = 1'b0;
    repeat (3) begin
      step();
      if (icache_rd_en === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL drop_no_early_req got=%h exp=0", seen); end
    respond(mkline(7));
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drop_discarded got=%h exp=1", empty); end
    wait_req(found, pc);
    checks++; if (!found || pc !== 32'h100) begin errors++; $display("FAIL drop_req100 got=%h/%h exp=1/00000100", found, pc); end
    respond(mkline(5));
    checks++; if (pc_out !== 32'h108 || inst !== 32'hA000_0502) begin errors++; $display("FAIL drop_first_inst got=%h/%h exp=00000108/a0000502", pc_out, inst); end
    rd_en = 1'b1;
    step();
    checks++; if (pc_out !== 32'h10C || inst !== 32'hA000_0503) begin errors++; $display("FAIL drop_second_inst got=%h/%h exp=0000010c/a0000503", pc_out, inst); end
    step();
    rd_en = 1'b0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drop_line_freed got=%h exp=1", empty); end
  endtask

  task automatic test_redirect_collision();
    bit found;
    logic [31:0] pc;
    do_reset();
    wait_req(found, pc);
    respond(mkline(0));
    wait_req(found, pc);
    checks++; if (!found || pc !== 32'h10) begin errors++; $display("FAIL coll_req10 got=%h/%h exp=1/00000010", found, pc); end
    rd_en = 1'b1;
    icache_dout = mkline(1);
    icache_dout_valid = 1'b1;
    jump_branch_address = 32'h200;
    jump_branch_valid = 1'b1;
    step();
    rd_en = 1'b0; icache_dout_valid = 1'b0; jump_branch_valid = 1'b0; icache_dout = '0;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL coll_empty got=%h exp=1", empty); end
    wait_req(found, pc);
    checks++; if (!found || pc !== 32'h200) begin errors++; $display("FAIL coll_req200 got=%h/%h exp=1/00000200", found, pc); end
    respond(mkline(2));
    checks++; if (pc_out !== 32'h200 || inst !== 32'hA000_0200) begin errors++; $display("FAIL coll_first_inst got=%h/%h exp=00000200/a0000200", pc_out, inst); end
  endtask

  task automatic test_async_reset();
    bit found;
    logic [31:0] pc;
    do_reset();
    wait_req(found, pc);
    respond(mkline(0));
    step();
    checks++; if (empty !== 1'b0 || icache_rd_en !== 1'b1) begin errors++; $display("FAIL arst_pre got=%h/%h exp=0/1", empty, icache_rd_en); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL arst_empty got=%h exp=1", empty); end
    checks++; if (icache_rd_en !== 1'b0) begin errors++; $display("FAIL arst_rd_en got=%h exp=0", icache_rd_en); end
    checks++; if (icache_pc_in !== 32'h0) begin errors++; $display("FAIL arst_pc_in got=%h exp=0", icache_pc_in); end
    checks++; if (pc_out !== 32'h0 || inst !== 32'h0) begin errors++; $display("FAIL arst_head got=%h/%h exp=0/0", pc_out, inst); end
    #1;
    rst = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_line();
    test_fifo_full();
    test_redirect_drop();
    test_redirect_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
